result_streamer: RTL and testbench
==================================

// Module: result_streamer
// PURPOSE
//  Reads 40-bit filter results from result RAM and streams them byte-wise to the UART TX core
//  (START/BUSY/DATA handshake), LSB byte first, with an optional sync header byte per frame.
//  It is the read/transmit counterpart of the RX sample packer, which writes 16-bit samples
//  into sample RAM. It sits between the result RAM read port and the UART TX core.
// PARAMETERS
//  ADDR_W        10     result RAM address width
//  NUM_WORDS     1024   words per frame; legal range 1..2**ADDR_W
//  BYTES_PER_WD  5      bytes sent per word; data width = 8*BYTES_PER_WD
//  RD_LAT        2      cycles from rd_en to valid rd_data (1..4)
//  HEADER_EN     1      1: send SYNC_BYTE before word 0
//  SYNC_BYTE     8'hA5  header value
//  ACK_TIMEOUT   16     max cycles from TX_START to TX_BUSY rising
// PORTS
//  CLOCK_50    in   1        system clock; all logic on posedge
//  RST_N       in   1        async active-low reset
//  TX_EN       in   1        level; sampled in IDLE, starts a frame
//  ABORT       in   1        abandon frame, return to IDLE
//  rd_data     in   40       result RAM read data
//  rd_en       out  1        RAM read strobe, 1 cycle per word
//  rd_address  out  ADDR_W   RAM read address
//  TX_DATA     out  8        byte to UART TX; held stable from TX_START until BUSY falls
//  TX_START    out  1        one-cycle start pulse to UART TX
//  TX_BUSY     in   1        UART TX busy
//  ACTIVE      out  1        high in every state except IDLE
//  DONE        out  1        one-cycle pulse when the frame's last byte completes
//  ERR         out  1        sticky; set on ACK timeout; cleared by reset or next accepted TX_EN
// BEHAVIOUR
//  Reset: all outputs 0; rd_address=0; state IDLE; shift register and counters cleared.
//  States: IDLE, HDR, FETCH, WAIT_RD, SEND, WAIT_ACK, WAIT_DONE, NEXT.
//  IDLE: if TX_EN=1 and TX_BUSY=0 -> clear ERR, rd_address=0, go to HDR if HEADER_EN else FETCH.
//   TX_EN held high after a frame finishes starts a new frame on the next idle cycle.
//  HDR: load SYNC_BYTE into the shift register; byte_cnt = BYTES_PER_WD-1 (last byte) -> SEND.
//   After the header completes, NEXT-style logic goes to FETCH with the address unchanged.
//  FETCH: rd_en=1 for exactly one cycle at rd_address -> WAIT_RD.
//  WAIT_RD: count RD_LAT cycles, then capture rd_data into shift reg, byte_cnt=0 -> SEND.
//  SEND: TX_DATA=sreg[7:0]; TX_START=1 for this cycle only -> WAIT_ACK.
//  WAIT_ACK: wait for TX_BUSY=1 -> WAIT_DONE. If ACK_TIMEOUT cycles elapse: set ERR, go IDLE, no DONE.
//  WAIT_DONE: on TX_BUSY=0, sreg >>= 8.
//   If byte_cnt==BYTES_PER_WD-1 -> NEXT; else byte_cnt++ -> SEND.
//  NEXT: if rd_address==NUM_WORDS-1: DONE=1, rd_address<=0 -> IDLE; else rd_address++ -> FETCH.
//  Per-byte cost: 1 SEND + ack wait + UART frame time. No bytes are skipped.
//  rd_address never exceeds NUM_WORDS-1. Wrap to 0 occurs only at frame end.
//  ABORT: priority over everything except reset.
//   In any non-IDLE state, next cycle goes to IDLE with rd_address=0 and TX_START=0; no DONE, ERR unchanged.
//   A byte already in the UART completes inside the TX core.
//  ABORT and TX_EN both high in IDLE: ABORT wins; the frame does not start.
//  Reset mid-frame: immediate return to reset values; no partial DONE.
//  rd_data is sampled only on the WAIT_RD exit cycle.
// TESTING
//  Single frame: NUM_WORDS=2, HEADER_EN=1, RAM={40'h0504030201, 40'h0A09080706}, TX_EN pulse
//   -> TX bytes A5,01,02,03,04,05,06,07,08,09,0A; exactly one DONE; rd_address back to 0.
//  Handshake: TX model raises BUSY 3 cycles after START and holds it 20 cycles
//   -> exactly one TX_START per byte; TX_DATA stable while BUSY is high.
//  Timeout: TX model never raises BUSY -> ERR=1 after 16 cycles; state IDLE; DONE never pulses.
//  Abort: assert ABORT during word 1 byte 2 -> ACTIVE=0 the next cycle; no further TX_START.
//   A later TX_EN restarts from header/address 0.
//  Reset: RST_N low during WAIT_DONE -> all outputs 0 asynchronously.
//   After release, a frame runs cleanly with no DONE from the aborted frame.
//  Wrap and back-to-back: NUM_WORDS=1024 with TX_EN held high
//   -> addresses 0..1023 read once each, DONE, then a new frame starts at address 0.

Source files
------------

// File: rtl/result_streamer_if.sv
// Result streamer bus: the result RAM read port plus the UART TX
// START/BUSY/DATA handshake. The streamer drives it through the master
// modport. The RAM and UART TX side, or a bench, uses the slave modport.
interface result_streamer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 40
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        TX_DATA;
    logic              TX_START;
    logic              TX_BUSY;

    modport master (
        output rd_en,
        output rd_address,
        input  rd_data,
        output TX_DATA,
        output TX_START,
        input  TX_BUSY
    );

    modport slave (
        input  rd_en,
        input  rd_address,
        output rd_data,
        input  TX_DATA,
        input  TX_START,
        output TX_BUSY
    );
endinterface

// File: rtl/result_streamer.sv
// Result streamer: reads wide filter results from the result RAM and sends
// them byte-wise to the UART TX core, LSB byte first. An optional sync
// header byte can precede word 0 of each frame. Every output is a flop.
// Each output is computed from the next state, so it lines up with the
// state it belongs to.
module result_streamer #(
    parameter int         ADDR_W       = 10,
    parameter int         NUM_WORDS    = 1024,
    parameter int         BYTES_PER_WD = 5,
    parameter int         RD_LAT       = 2,
    parameter bit         HEADER_EN    = 1'b1,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         ACK_TIMEOUT  = 16
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic              TX_EN,
    input  logic              ABORT,
    output logic              ACTIVE,
    output logic              DONE,
    output logic              ERR,
    result_streamer_if.master bus
);

    localparam int DATA_W = 8 * BYTES_PER_WD;
    localparam int BCNT_W = (BYTES_PER_WD > 1) ? $clog2(BYTES_PER_WD) : 1;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WD - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(RD_LAT - 1);
    localparam logic [ACK_W-1:0]  LAST_ACK  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_WAIT_RD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   rd_address_q, rd_address_d;
    logic [DATA_W-1:0]   sreg_q,       sreg_d;
    logic [BCNT_W-1:0]   byte_cnt_q,   byte_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q,    lat_cnt_d;
    logic [ACK_W-1:0]    ack_cnt_q,    ack_cnt_d;
    // Set while the sync header byte is in flight. The NEXT state then
    // moves on to word 0 without advancing the address.
    logic                hdr_q,        hdr_d;
    logic                rd_en_q,      rd_en_d;
    logic                tx_start_q,   tx_start_d;
    logic [7:0]          tx_data_q,    tx_data_d;
    logic                active_q,     active_d;
    logic                done_q,       done_d;
    logic                err_q,        err_d;

    // Next-state, datapath and registered-output computation for the FSM.
    always_comb begin
        // NOTE: every signal assigned below gets a default here first, so no
        // path through the case statement can leave a latch behind.
        state_d      = state_q;
        rd_address_d = rd_address_q;
        sreg_d       = sreg_q;
        byte_cnt_d   = byte_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        hdr_d        = hdr_q;
        err_d        = err_q;
        done_d       = 1'b0;

        if (ABORT) begin
            // ABORT overrides everything. In IDLE it only stops a frame from
            // starting. A byte already handed to the UART still finishes in
            // the TX core.
            state_d      = S_IDLE;
            rd_address_d = '0;
            hdr_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (TX_EN && !bus.TX_BUSY) begin
                        err_d        = 1'b0;
                        rd_address_d = '0;
                        hdr_d        = HEADER_EN;
                        state_d      = HEADER_EN ? S_HDR : S_FETCH;
                    end
                end
                S_HDR: begin
                    // The header is sent as a one-byte "word". byte_cnt starts
                    // at the last index, so WAIT_DONE goes straight to NEXT.
                    sreg_d     = DATA_W'(SYNC_BYTE);
                    byte_cnt_d = LAST_BYTE;
                    state_d    = S_SEND;
                end
                S_FETCH: begin
                    lat_cnt_d = '0;
                    state_d   = S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    // rd_data is sampled only on the last latency cycle.
                    if (lat_cnt_q == LAST_LAT) begin
                        sreg_d     = bus.rd_data;
                        byte_cnt_d = '0;
                        state_d    = S_SEND;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end
                S_SEND: begin
                    ack_cnt_d = '0;
                    state_d   = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.TX_BUSY) begin
                        state_d = S_WAIT_DONE;
                    end else if (ack_cnt_q == LAST_ACK) begin
                        // The UART never acknowledged. Drop the frame and flag
                        // it. DONE does not pulse.
                        err_d        = 1'b1;
                        rd_address_d = '0;
                        hdr_d        = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + ACK_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.TX_BUSY) begin
                        sreg_d = sreg_q >> 8;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = S_NEXT;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                            state_d    = S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = S_FETCH;
                    end else if (rd_address_q == LAST_ADDR) begin
                        // The address wraps to 0 only here, at the end of a
                        // frame, so it never passes NUM_WORDS-1.
                        done_d       = 1'b1;
                        rd_address_d = '0;
                        state_d      = S_IDLE;
                    end else begin
                        rd_address_d = rd_address_q + ADDR_W'(1);
                        state_d      = S_FETCH;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    rd_address_d = '0;
                    hdr_d        = 1'b0;
                end
            endcase
        end

        // Outputs are decoded from the next state, so the registered copies
        // are valid during the state they belong to.
        rd_en_d    = (state_d == S_FETCH);
        tx_start_d = (state_d == S_SEND);
        active_d   = (state_d != S_IDLE);
        // TX_DATA changes only when a new byte is launched. It therefore
        // stays stable from TX_START until BUSY falls.
        tx_data_d  = (state_d == S_SEND) ? sreg_d[7:0] : tx_data_q;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            rd_address_q <= '0;
            sreg_q       <= '0;
            byte_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            ack_cnt_q    <= '0;
            hdr_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its value
            // from the same pre-edge snapshot, independent of statement order.
            state_q      <= state_d;
            rd_address_q <= rd_address_d;
            sreg_q       <= sreg_d;
            byte_cnt_q   <= byte_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            hdr_q        <= hdr_d;
            rd_en_q      <= rd_en_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            active_q     <= active_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_address = rd_address_q;
    assign bus.TX_DATA    = tx_data_q;
    assign bus.TX_START   = tx_start_q;
    assign ACTIVE         = active_q;
    assign DONE           = done_q;
    assign ERR            = err_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer. dut streams a 2-word frame against a
// configurable UART TX model. dut_w streams a full 1024-word frame against a
// fast TX model to exercise the address wrap and back-to-back frames.
module tb_result_streamer;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 40;
    localparam int RD_LAT  = 2;
    localparam int W_WORDS = 1024;
    localparam logic [DATA_W-1:0] GARBAGE = 40'hEE_EEEE_EEEE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;
    logic abort = 1'b0;
    logic active, done, err;
    logic tx_en_w = 1'b0;
    logic abort_w = 1'b0;
    logic active_w, done_w, err_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    result_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_w ();

    result_streamer #(
        .ADDR_W(ADDR_W), .NUM_WORDS(2), .BYTES_PER_WD(5), .RD_LAT(RD_LAT),
        .HEADER_EN(1'b1), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(16)
    ) dut (
        .CLOCK_50(clk), .RST_N(rst_n), .TX_EN(tx_en), .ABORT(abort),
        .ACTIVE(active), .DONE(done), .ERR(err), .bus(bus)
    );

    result_streamer #(
        .ADDR_W(ADDR_W), .NUM_WORDS(W_WORDS), .BYTES_PER_WD(5), .RD_LAT(RD_LAT),
        .HEADER_EN(1'b1), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(16)
    ) dut_w (
        .CLOCK_50(clk), .RST_N(rst_n), .TX_EN(tx_en_w), .ABORT(abort_w),
        .ACTIVE(active_w), .DONE(done_w), .ERR(err_w), .bus(bus_w)
    );

    // ---------------- reference data ----------------
    logic [7:0] exp_frame [11] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};

    function automatic logic [DATA_W-1:0] word1(input logic [ADDR_W-1:0] a);
        return (a == 10'd1) ? 40'h0A09080706 : 40'h0504030201;
    endfunction

    function automatic logic [DATA_W-1:0] word_w(input int a);
        return {8'(a >> 2), 8'(a + 3), 8'(~a), 8'(a >> 8), 8'(a)};
    endfunction

    function automatic logic [7:0] exp_w_byte(input int idx);
        logic [DATA_W-1:0] d;
        int w, k;
        if (idx == 0) return 8'hA5;
        w = (idx - 1) / 5;
        k = (idx - 1) % 5;
        d = word_w(w);
        return d[8*k +: 8];
    endfunction

    // ---------------- RAM models (data valid exactly RD_LAT cycles after rd_en) ----------------
    logic [DATA_W-1:0] pipe1 [RD_LAT+1];
    logic [DATA_W-1:0] pipe_w [RD_LAT+1];
    int oob_cnt = 0;

    always @(negedge clk) begin
        if (bus.rd_en === 1'b1) begin
            if (bus.rd_address < 10'd2) pipe1[0] <= word1(bus.rd_address);
            else begin
                pipe1[0] <= GARBAGE;
                oob_cnt++;
            end
        end else begin
            pipe1[0] <= GARBAGE;
        end
        for (int k = 1; k <= RD_LAT; k++) pipe1[k] <= pipe1[k-1];
    end
    assign bus.rd_data = pipe1[RD_LAT];

    always @(negedge clk) begin
        if (bus_w.rd_en === 1'b1) pipe_w[0] <= word_w(int'(bus_w.rd_address));
        else pipe_w[0] <= GARBAGE;
        for (int k = 1; k <= RD_LAT; k++) pipe_w[k] <= pipe_w[k-1];
    end
    assign bus_w.rd_data = pipe_w[RD_LAT];

    // ---------------- UART TX model for dut ----------------
    int busy_delay = 3;
    int busy_hold = 20;
    logic never_busy = 1'b0;
    int m_state = 0;
    int m_cnt = 0;
    logic busy_m = 1'b0;
    logic [7:0] held_m = 8'h00;
    int start_cnt = 0;
    int extra_start = 0;
    int unstable = 0;
    int done_cnt = 0;
    logic [7:0] bytes [$];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        case (m_state)
            0: if (bus.TX_START === 1'b1) begin
                start_cnt++;
                bytes.push_back(bus.TX_DATA);
                held_m = bus.TX_DATA;
                if (!never_busy) begin
                    m_state = 1;
                    m_cnt = busy_delay - 1;
                end
            end
            1: begin
                if (bus.TX_START === 1'b1) extra_start++;
                if (m_cnt == 0) begin
                    busy_m = 1'b1;
                    m_state = 2;
                    m_cnt = busy_hold - 1;
                end else m_cnt--;
            end
            default: begin
                if (bus.TX_START === 1'b1) extra_start++;
                if (bus.TX_DATA !== held_m) unstable++;
                if (m_cnt == 0) begin
                    busy_m = 1'b0;
                    m_state = 0;
                end else m_cnt--;
            end
        endcase
    end
    assign bus.TX_BUSY = busy_m;

    // ---------------- fast UART TX model and frame monitor for dut_w ----------------
    logic busy_w = 1'b0;
    int busy_w_cnt = 0;
    int w_idx = 0;
    int w_byte_err = 0;
    int w_bytes_at_done = -1;
    int done_w_cnt = 0;
    int w_exp_addr = 0;
    int w_order_err = 0;
    int first_after = -1;
    int rdcnt [W_WORDS] = '{default: 0};

    always @(negedge clk) begin
        if (bus_w.TX_START === 1'b1) begin
            busy_w = 1'b1;
            busy_w_cnt = 2;
            if (bus_w.TX_DATA !== exp_w_byte(w_idx)) w_byte_err++;
            w_idx++;
        end else if (busy_w_cnt > 1) begin
            busy_w_cnt--;
        end else begin
            busy_w = 1'b0;
            busy_w_cnt = 0;
        end
        if (bus_w.rd_en === 1'b1) begin
            if (done_w_cnt == 0) begin
                rdcnt[bus_w.rd_address]++;
                if (int'(bus_w.rd_address) != w_exp_addr) w_order_err++;
                w_exp_addr++;
            end else if (first_after < 0) begin
                first_after = int'(bus_w.rd_address);
            end
        end
        if (done_w === 1'b1) begin
            done_w_cnt++;
            if (done_w_cnt == 1) w_bytes_at_done = w_idx;
            w_idx = 0;
        end
    end
    assign bus_w.TX_BUSY = busy_w;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Runs one full 2-word frame on dut from a TX_EN pulse and checks it.
    task automatic run_frame(input string tag);
        int b_start, b_done, b_bytes, b_extra, b_unst, n;
        logic [7:0] got;
        b_start = start_cnt;
        b_done  = done_cnt;
        b_bytes = bytes.size();
        b_extra = extra_start;
        b_unst  = unstable;
        tx_en = 1'b1;
        step(1);
        tx_en = 1'b0;
        check({tag, "_active"}, 64'(active), 64'd1);
        for (n = 0; n < 2000 && done_cnt == b_done; n++) step(1);
        step(3);
        check({tag, "_done_count"}, 64'(done_cnt - b_done), 64'd1);
        check({tag, "_start_count"}, 64'(start_cnt - b_start), 64'd11);
        check({tag, "_extra_start"}, 64'(extra_start - b_extra), 64'd0);
        check({tag, "_data_stable"}, 64'(unstable - b_unst), 64'd0);
        for (int i = 0; i < 11; i++) begin
            got = (b_bytes + i < bytes.size()) ? bytes[b_bytes + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 64'(got), 64'(exp_frame[i]));
        end
        check({tag, "_addr_back_to_0"}, 64'(bus.rd_address), 64'd0);
        check({tag, "_idle_after"}, 64'(active), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // Global safety net: stop with a FAIL line if the run somehow overruns.
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, b_start, b_done, b_bytes, bad;

        // Reset values
        step(3);
        check("rst_active", 64'(active), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("rst_rd_address", 64'(bus.rd_address), 64'd0);
        check("rst_tx_start", 64'(bus.TX_START), 64'd0);
        check("rst_tx_data", 64'(bus.TX_DATA), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Single frame with the slow handshake (BUSY 3 cycles after START, held 20)
        run_frame("frame1");
        check("frame1_no_oob_read", 64'(oob_cnt), 64'd0);

        // ACK timeout: BUSY never rises
        never_busy = 1'b1;
        b_start = start_cnt;
        b_done = done_cnt;
        tx_en = 1'b1;
        step(1);
        tx_en = 1'b0;
        for (n = 0; n < 50 && bus.TX_START !== 1'b1; n++) step(1);
        check("to_start_seen", 64'(bus.TX_START), 64'd1);
        step(16);
        check("to_err_before", 64'(err), 64'd0);
        check("to_active_before", 64'(active), 64'd1);
        step(1);
        check("to_err_set", 64'(err), 64'd1);
        check("to_idle", 64'(active), 64'd0);
        step(20);
        check("to_no_done", 64'(done_cnt - b_done), 64'd0);
        check("to_one_start", 64'(start_cnt - b_start), 64'd1);
        check("to_err_sticky", 64'(err), 64'd1);
        never_busy = 1'b0;

        // ABORT and TX_EN together in IDLE: the frame must not start
        abort = 1'b1;
        tx_en = 1'b1;
        step(1);
        check("abort_en_idle_active", 64'(active), 64'd0);
        step(2);
        check("abort_en_idle_active2", 64'(active), 64'd0);
        check("abort_en_err_kept", 64'(err), 64'd1);
        check("abort_en_no_start", 64'(bus.TX_START), 64'd0);
        abort = 1'b0;
        tx_en = 1'b0;
        step(1);

        // ABORT during word 1 byte 2 (9th byte of the frame)
        b_start = start_cnt;
        b_done = done_cnt;
        b_bytes = bytes.size();
        tx_en = 1'b1;
        step(1);
        tx_en = 1'b0;
        check("ab_err_cleared", 64'(err), 64'd0);
        for (n = 0; n < 1000 && start_cnt < b_start + 9; n++) step(1);
        check("ab_reached_byte", 64'(start_cnt - b_start), 64'd9);
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("ab_active_low", 64'(active), 64'd0);
        check("ab_tx_start_low", 64'(bus.TX_START), 64'd0);
        check("ab_addr_0", 64'(bus.rd_address), 64'd0);
        check("ab_last_byte", 64'((b_bytes + 8 < bytes.size()) ? bytes[b_bytes + 8] : 8'hxx), 64'h08);
        step(60);
        check("ab_no_more_start", 64'(start_cnt - b_start), 64'd9);
        check("ab_no_done", 64'(done_cnt - b_done), 64'd0);
        check("ab_err_unchanged", 64'(err), 64'd0);
        run_frame("restart");

        // Asynchronous reset while dut waits for BUSY to fall on word 1 byte 0
        b_start = start_cnt;
        b_done = done_cnt;
        tx_en = 1'b1;
        step(1);
        tx_en = 1'b0;
        for (n = 0; n < 1000 && !(start_cnt >= b_start + 7 && busy_m === 1'b1); n++) step(1);
        check("rs_addr_before", 64'(bus.rd_address), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_active", 64'(active), 64'd0);
        check("rs_rd_address", 64'(bus.rd_address), 64'd0);
        check("rs_tx_data", 64'(bus.TX_DATA), 64'd0);
        check("rs_tx_start", 64'(bus.TX_START), 64'd0);
        check("rs_rd_en", 64'(bus.rd_en), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        check("rs_err", 64'(err), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(30);
        check("rs_no_partial_done", 64'(done_cnt - b_done), 64'd0);
        run_frame("post_reset");

        // Wrap and back-to-back on the 1024-word instance with TX_EN held high
        tx_en_w = 1'b1;
        for (n = 0; n < 40000 && done_w_cnt == 0; n++) step(1);
        for (n = 0; n < 200 && first_after < 0; n++) step(1);
        check("wrap_done_once", 64'(done_w_cnt), 64'd1);
        check("wrap_bytes_in_frame", 64'(w_bytes_at_done), 64'd5121);
        check("wrap_byte_values", 64'(w_byte_err), 64'd0);
        check("wrap_addr_order", 64'(w_order_err), 64'd0);
        bad = 0;
        for (int i = 0; i < W_WORDS; i++) if (rdcnt[i] != 1) bad++;
        check("wrap_each_addr_once", 64'(bad), 64'd0);
        check("wrap_restart_addr", 64'(first_after), 64'd0);
        check("wrap_active_again", 64'(active_w), 64'd1);
        check("wrap_err", 64'(err_w), 64'd0);
        tx_en_w = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
